// File: rtl/if_stage_pkg.sv
// if_stage_pkg: cpu-wide bus widths, NOP encoding and fetch FSM encodings
package if_stage_pkg;
    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam logic [WORD_DATA_W-1:0] ISA_NOP = '0;
    localparam logic BUS_READ = 1'b1;
    typedef enum logic [1:0] {IF_IDLE, IF_REQ, IF_ACCESS} if_state_t;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch bus between the IF stage (master) and the bus arbiter/memory (slave)
interface if_stage_if
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = WORD_ADDR_W,
    parameter int DATA_W = WORD_DATA_W
);
    logic              bus_req;
    logic              bus_grant;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy;
    modport master (output bus_req, bus_addr, bus_as, bus_rw, input bus_grant, bus_rd_data, bus_rdy);
    modport slave (input bus_req, bus_addr, bus_as, bus_rw, output bus_grant, bus_rd_data, bus_rdy);
endinterface

// File: rtl/if_stage_reg.sv
// if_reg: IF/ID pipeline register with reset > flush > stall > abort > fetch > bubble priority
module if_reg
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = WORD_ADDR_W,
    parameter int DATA_W = WORD_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid,
    input  logic              tmo,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] insn,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              if_bus_err
);
    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc      <= RESET_VECTOR;
            if_insn    <= DATA_W'(ISA_NOP);
            if_en      <= 1'b0;
            if_bus_err <= 1'b0;
        end else if (flush) begin
            if_insn    <= DATA_W'(ISA_NOP);
            if_en      <= 1'b0;
            if_bus_err <= 1'b0;
        end else if (!stall) begin
            if (tmo) begin
                if_insn    <= DATA_W'(ISA_NOP);
                if_en      <= 1'b1;
                if_bus_err <= 1'b1;
            end else if (valid) begin
                if_pc      <= pc;
                if_insn    <= insn;
                if_en      <= 1'b1;
                if_bus_err <= 1'b0;
            end else begin
                if_en <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage owning the PC and the fetch bus master FSM.
// Define IF_BUS_TIMEOUT_EN to enable the fetch watchdog that aborts a stuck access.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int ADDR_W = WORD_ADDR_W,
    parameter int DATA_W = WORD_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              busy,
    if_stage_if.master        bus,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              if_bus_err
);
    if_state_t         state, state_n;
    logic              req_q, as_q, kill, done, fire, tmo;
    logic [ADDR_W-1:0] pc;
    // done: data is on the bus; fire: the access retires (a stall keeps it parked with as held)
    assign done = state == IF_ACCESS && as_q && bus.bus_rdy;
    assign fire = done && (flush || !stall);
    assign busy = !done;
    assign bus.bus_req  = req_q;
    assign bus.bus_as   = as_q;
    assign bus.bus_addr = pc;
    assign bus.bus_rw   = BUS_READ;
`ifdef IF_BUS_TIMEOUT_EN
    logic [7:0] cnt;
    assign tmo = state == IF_ACCESS && cnt == 8'(TIMEOUT_CYC) && !flush && !stall;
    always_ff @(posedge clk) begin
        cnt <= (reset || state != IF_ACCESS || done) ? '0 : cnt == 8'(TIMEOUT_CYC) ? cnt : cnt + 8'd1;
    end
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_n = tmo ? IF_IDLE :
                  state == IF_IDLE ? IF_REQ :
                  state == IF_REQ ? (bus.bus_grant ? IF_ACCESS : IF_REQ) :
                  (fire && !bus.bus_grant) ? IF_REQ : IF_ACCESS;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IF_IDLE;
            req_q <= 1'b0;
            as_q  <= 1'b0;
            kill  <= 1'b0;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_n;
            req_q <= state_n != IF_IDLE;
            as_q  <= state_n == IF_ACCESS && !fire;
            // a flush mid-access lets the bus cycle finish but throws its data away
            kill  <= (done || tmo) ? 1'b0 : (flush && state == IF_ACCESS && as_q) ? 1'b1 : kill;
            pc    <= flush ? new_pc : (fire && !kill) ? (br_taken ? br_addr : pc + ADDR_W'(1)) : pc;
        end
    end
    if_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_VECTOR(RESET_VECTOR)) u_if_reg (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .stall      (stall),
        .valid      (done && !kill),
        .tmo        (tmo),
        .pc         (pc),
        .insn       (bus.bus_rd_data),
        .if_pc      (if_pc),
        .if_insn    (if_insn),
        .if_en      (if_en),
        .if_bus_err (if_bus_err)
    );
endmodule
